// File: rtl/qmem_pkg.sv
// Shared qmem definitions: arbiter state encoding, default bus widths and
// a small one-hot helper used by the qmem schedulers.
package qmem_pkg;

  localparam int unsigned QM_QAW = 32;
  localparam int unsigned QM_QDW = 32;

  typedef enum logic {
    QM_IDLE = 1'b0,
    QM_BUSY = 1'b1
  } qm_state_e;

  function automatic logic [7:0] qm_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/qmem_rr_pick.sv
// Rotating priority encoder: returns the first requester after `last`,
// wrapping modulo MN.
module qmem_rr_pick #(
  parameter int unsigned MN = 4
) (
  input  logic [MN-1:0] req,
  input  logic [2:0]    last,
  output logic          valid,
  output logic [2:0]    idx
);

  logic [7:0] req8;

  assign req8 = 8'(req);

  // Walk the ring from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int unsigned k = MN; k >= 1; k--) begin
      if (req8[3'((32'(last) + k) % MN)]) begin
        valid = 1'b1;
        idx   = 3'((32'(last) + k) % MN);
      end
    end
  end

endmodule

// File: rtl/qmem_rr_arbiter.sv
// Round-robin qmem arbiter with registered grant, per-master lock for atomic
// sequences and a watchdog that ends stalled accesses with an error.
module qmem_rr_arbiter
  import qmem_pkg::*;
#(
  parameter int unsigned QAW = QM_QAW,
  parameter int unsigned QDW = QM_QDW,
  parameter int unsigned QSW = QDW / 8,
  parameter int unsigned MN  = 4,
  parameter int unsigned TOW = 8,
  parameter int unsigned TO  = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MN-1:0]     qm_cs,
  input  logic [MN-1:0]     qm_we,
  input  logic [MN-1:0]     qm_lock,
  input  logic [MN*QSW-1:0] qm_sel,
  input  logic [MN*QAW-1:0] qm_adr,
  input  logic [MN*QDW-1:0] qm_dat_w,
  output logic [MN*QDW-1:0] qm_dat_r,
  output logic [MN-1:0]     qm_ack,
  output logic [MN-1:0]     qm_err,
  output logic              qs_cs,
  output logic              qs_we,
  output logic [QSW-1:0]    qs_sel,
  output logic [QAW-1:0]    qs_adr,
  output logic [QDW-1:0]    qs_dat_w,
  input  logic [QDW-1:0]    qs_dat_r,
  input  logic              qs_ack,
  input  logic              qs_err,
  output logic [MN-1:0]     ms
);

  localparam logic [TOW-1:0] TO_LAST = TOW'((TO == 0) ? 0 : TO - 1);

  qm_state_e      state_q, state_d;
  logic [2:0]     gnt_q, gnt_d;
  logic [2:0]     last_q, last_d;
  logic [TOW-1:0] tcnt_q, tcnt_d;

  logic       pick_valid;
  logic [2:0] pick_idx;
  logic       busy, cs_g, lock_g, qs_cs_raw, tmo, term;

  qmem_rr_pick #(.MN(MN)) u_pick (
    .req   (qm_cs),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Request mux from the granted master; master 0 when nothing else matches.
  always_comb begin
    cs_g     = qm_cs[0];
    lock_g   = qm_lock[0];
    qs_we    = qm_we[0];
    qs_sel   = qm_sel[QSW-1:0];
    qs_adr   = qm_adr[QAW-1:0];
    qs_dat_w = qm_dat_w[QDW-1:0];
    for (int unsigned i = 1; i < MN; i++) begin
      if (gnt_q == 3'(i)) begin
        cs_g     = qm_cs[i];
        lock_g   = qm_lock[i];
        qs_we    = qm_we[i];
        qs_sel   = qm_sel[QSW*i +: QSW];
        qs_adr   = qm_adr[QAW*i +: QAW];
        qs_dat_w = qm_dat_w[QDW*i +: QDW];
      end
    end
  end

  // Reset masks the bus immediately so an in-flight access is dropped silently.
  assign busy      = (state_q == QM_BUSY) && !rst;
  assign qs_cs_raw = busy && cs_g;
  assign tmo       = (TO != 0) && (tcnt_q == TO_LAST) && qs_cs_raw && !qs_ack && !qs_err;
  assign term      = busy && (qs_ack || qs_err || tmo);

  assign qs_cs    = qs_cs_raw && !tmo;
  assign ms       = busy ? MN'(qm_onehot(gnt_q)) : '0;
  assign qm_ack   = qs_ack ? ms : '0;
  assign qm_err   = (qs_err || tmo) ? ms : '0;
  assign qm_dat_r = {MN{qs_dat_r}};

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      QM_IDLE: begin
        tcnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_idx;
          state_d = QM_BUSY;
        end
      end
      QM_BUSY: begin
        if (term) begin
          last_d = gnt_q;
          tcnt_d = '0;
          if (!lock_g) state_d = QM_IDLE;
        end else if (!cs_g && !lock_g) begin
          last_d  = gnt_q;
          state_d = QM_IDLE;
        end else if (qs_cs && (TO != 0)) begin
          tcnt_d = tcnt_q + TOW'(1);
        end
      end
      default: state_d = QM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= QM_IDLE;
      gnt_q   <= 3'd0;
      last_q  <= 3'(MN - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_qmem_rr_arbiter.sv
// Scoreboard bench for qmem_rr_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_qmem_rr_arbiter;

  localparam int MN  = 4;
  localparam int TO  = 5;
  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;

  logic              clk;
  logic              rst;
  logic [MN-1:0]     qm_cs, qm_we, qm_lock;
  logic [MN*QSW-1:0] qm_sel;
  logic [MN*QAW-1:0] qm_adr;
  logic [MN*QDW-1:0] qm_dat_w;
  logic [MN*QDW-1:0] qm_dat_r;
  logic [MN-1:0]     qm_ack, qm_err;
  logic              qs_cs, qs_we;
  logic [QSW-1:0]    qs_sel;
  logic [QAW-1:0]    qs_adr;
  logic [QDW-1:0]    qs_dat_w;
  logic [QDW-1:0]    qs_dat_r;
  logic              qs_ack, qs_err;
  logic [MN-1:0]     ms;

  qmem_rr_arbiter #(
    .QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .TOW(8), .TO(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .qm_cs(qm_cs), .qm_we(qm_we), .qm_lock(qm_lock), .qm_sel(qm_sel),
    .qm_adr(qm_adr), .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r),
    .qm_ack(qm_ack), .qm_err(qm_err),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
    .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .ms(ms)
  );

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  typedef struct {
    int          m;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   rlog_m[$], rlog_c[$], plog_c[$];
  logic [3:0] plog_ack[$], plog_err[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: who owns the slave, who was served last, how long we waited.
  int m_owner = -1;
  int m_last  = MN - 1;
  int m_wait  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic ok, input string det);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", nm, det);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then step past the edge.
  task automatic cyc_drive(input logic r, input logic [3:0] cs, input logic [3:0] lk,
                           input int ack_pct, input int err_pct, input int spur_pct,
                           input int ack_at);
    logic raw, a, e, tmo;
    int   nxt;
    req_t rq;
    rsp_t rp;
    rst     = r;
    qm_cs   = cs;
    qm_lock = lk;
    qm_we   = 4'($urandom);
    for (int i = 0; i < MN; i++) begin
      qm_adr[32*i +: 32]   = $urandom;
      qm_dat_w[32*i +: 32] = $urandom;
      qm_sel[4*i +: 4]     = 4'($urandom);
    end
    qs_dat_r = $urandom;
    raw = !r && (m_owner >= 0) && cs[m_owner];
    if (raw) begin
      a = (ack_at >= 0) ? (m_wait == ack_at) : (int'($urandom_range(99)) < ack_pct);
      e = (ack_at < 0) && (int'($urandom_range(99)) < err_pct);
    end else begin
      a = int'($urandom_range(99)) < spur_pct;
      e = int'($urandom_range(99)) < spur_pct;
    end
    qs_ack = a;
    qs_err = e;

    if (r) begin
      m_owner = -1;
      m_last  = MN - 1;
      m_wait  = 0;
    end else if (m_owner < 0) begin
      nxt = -1;
      for (int k = 1; k <= MN; k++)
        if (nxt < 0 && cs[(m_last + k) % MN]) nxt = (m_last + k) % MN;
      m_owner = nxt;
      m_wait  = 0;
    end else begin
      tmo = raw && (m_wait == TO - 1) && !a && !e;
      if (raw && !tmo) begin
        rq.m   = m_owner;
        rq.adr = qm_adr[32*m_owner +: 32];
        rq.we  = qm_we[m_owner];
        rq.sel = qm_sel[4*m_owner +: 4];
        rq.dat = qm_dat_w[32*m_owner +: 32];
        req_q.push_back(rq);
      end
      if (a || e || tmo) begin
        rp.m   = m_owner;
        rp.ack = a;
        rp.err = e || tmo;
        rp.dat = qs_dat_r;
        rsp_q.push_back(rp);
        m_last = m_owner;
        m_wait = 0;
        if (!lk[m_owner]) m_owner = -1;
      end else if (!cs[m_owner] && !lk[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (raw) begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a slave request or a response.
  always @(negedge clk) begin
    int   gi;
    req_t er;
    rsp_t ep;
    logic [3:0] am, em;
    gi = -1;
    for (int i = 0; i < MN; i++) if (ms[i] === 1'b1) gi = i;
    if (qs_cs === 1'b1) begin
      rlog_m.push_back(gi);
      rlog_c.push_back(cyc);
      n_tests++;
      if (req_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_extra: got master %0d adr %h, expected no request", gi, qs_adr);
      end else begin
        er = req_q.pop_front();
        if (gi != er.m || qs_adr !== er.adr || qs_we !== er.we ||
            qs_sel !== er.sel || qs_dat_w !== er.dat) begin
          n_fail++;
          $display("FAIL req: got m%0d adr %h we %b sel %h dat %h, expected m%0d adr %h we %b sel %h dat %h",
                   gi, qs_adr, qs_we, qs_sel, qs_dat_w, er.m, er.adr, er.we, er.sel, er.dat);
        end
      end
    end
    if ((qm_ack | qm_err) !== 4'b0000) begin
      plog_ack.push_back(qm_ack);
      plog_err.push_back(qm_err);
      plog_c.push_back(cyc);
      n_tests++;
      if (rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_extra: got ack %b err %b, expected no response", qm_ack, qm_err);
      end else begin
        ep = rsp_q.pop_front();
        am = ep.ack ? 4'(1 << ep.m) : 4'b0;
        em = ep.err ? 4'(1 << ep.m) : 4'b0;
        if (qm_ack !== am || qm_err !== em || qm_dat_r[32*ep.m +: 32] !== ep.dat) begin
          n_fail++;
          $display("FAIL rsp: got ack %b err %b dat %h, expected ack %b err %b dat %h",
                   qm_ack, qm_err, qm_dat_r[32*ep.m +: 32], am, em, ep.dat);
        end
      end
    end
  end

  initial begin
    int r0, p0;
    rst = 1'b1; qm_cs = '0; qm_we = '0; qm_lock = '0; qm_sel = '0;
    qm_adr = '0; qm_dat_w = '0; qs_dat_r = '0; qs_ack = 1'b0; qs_err = 1'b0;

    // Reset with every master requesting.
    cyc_drive(1'b1, 4'hF, 4'h0, 100, 0, 0, -1);
    chk("rst_ms", ms === 4'b0000, $sformatf("ms %b, expected 0000", ms));
    chk("rst_qs_cs", qs_cs === 1'b0, $sformatf("qs_cs %b, expected 0", qs_cs));
    cyc_drive(1'b1, 4'hF, 4'h0, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'hF, 4'h0, 100, 0, 0, -1);
    chk("rst_first_gnt", ms === 4'b0001, $sformatf("ms %b, expected 0001", ms));

    // Rotation with a wait-free slave.
    r0 = rlog_m.size();
    for (int n = 0; n < 9; n++) cyc_drive(1'b0, 4'hF, 4'h0, 100, 0, 0, -1);
    for (int k = 0; k < 5; k++)
      chk("rot_grant",
          (rlog_m.size() > r0 + k) ? (rlog_m[r0+k] == k % MN &&
            (k == 0 || rlog_c[r0+k] - rlog_c[r0+k-1] == 2)) : 1'b0,
          $sformatf("step %0d got master %0d, expected %0d every 2 cycles", k,
                    (rlog_m.size() > r0 + k) ? rlog_m[r0+k] : -1, k % MN));

    // Lock: master 2 keeps the slave for three accesses, then 0 is served.
    cyc_drive(1'b0, 4'b0010, 4'h0, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0010, 4'h0, 100, 0, 0, -1);
    r0 = rlog_m.size();
    cyc_drive(1'b0, 4'b0101, 4'b0000, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0101, 4'b0100, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0101, 4'b0100, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0101, 4'b0000, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0101, 4'b0000, 100, 0, 0, -1);
    cyc_drive(1'b0, 4'b0001, 4'b0000, 100, 0, 0, -1);
    chk("lock_seq",
        (rlog_m.size() == r0 + 4) ? (rlog_m[r0] == 2 && rlog_m[r0+1] == 2 &&
          rlog_m[r0+2] == 2 && rlog_m[r0+3] == 0) : 1'b0,
        $sformatf("%0d grants after lock start, expected 2,2,2,0", rlog_m.size() - r0));
    chk("lock_timing",
        (rlog_m.size() == r0 + 4) ? (rlog_c[r0+1] == rlog_c[r0] + 1 &&
          rlog_c[r0+2] == rlog_c[r0] + 2 && rlog_c[r0+3] == rlog_c[r0] + 4) : 1'b0,
        "grant spacing, expected +1,+1,+2 cycles");

    // Watchdog: master 1 never answered.
    r0 = rlog_m.size();
    p0 = plog_c.size();
    for (int n = 0; n < 6; n++) cyc_drive(1'b0, 4'b0010, 4'h0, 0, 0, 0, -1);
    cyc_drive(1'b0, 4'b0000, 4'h0, 0, 0, 0, -1);
    chk("tmo_err", (plog_c.size() == p0 + 1) ? (plog_err[p0] == 4'b0010 && plog_ack[p0] == 4'b0000) : 1'b0,
        $sformatf("%0d responses, expected one err=0010 ack=0000", plog_c.size() - p0));
    chk("tmo_qs_cs_cnt", rlog_m.size() == r0 + 4,
        $sformatf("%0d qs_cs cycles, expected 4", rlog_m.size() - r0));
    chk("tmo_cycle", (plog_c.size() > p0 && rlog_c.size() > r0) ? (plog_c[p0] == rlog_c[r0] + 4) : 1'b0,
        "err not in 5th cycle of qs_cs");

    // Ack on the last watchdog cycle beats the timeout.
    r0 = rlog_m.size();
    p0 = plog_c.size();
    for (int n = 0; n < 6; n++) cyc_drive(1'b0, 4'b0010, 4'h0, 0, 0, 0, TO - 1);
    cyc_drive(1'b0, 4'b0000, 4'h0, 0, 0, 0, -1);
    chk("edge_ack", (plog_c.size() == p0 + 1) ? (plog_ack[p0] == 4'b0010 && plog_err[p0] == 4'b0000) : 1'b0,
        $sformatf("%0d responses, expected one ack=0010 err=0000", plog_c.size() - p0));
    chk("edge_qs_cs_cnt", rlog_m.size() == r0 + 5,
        $sformatf("%0d qs_cs cycles, expected 5", rlog_m.size() - r0));

    // Reset while master 1 is stalled: access dropped, no response.
    r0 = rlog_m.size();
    p0 = plog_c.size();
    cyc_drive(1'b0, 4'b0010, 4'h0, 0, 0, 0, -1);
    cyc_drive(1'b0, 4'b0010, 4'h0, 0, 0, 0, -1);
    cyc_drive(1'b1, 4'b0010, 4'h0, 0, 0, 0, -1);
    cyc_drive(1'b0, 4'b0010, 4'h0, 0, 0, 0, -1);
    cyc_drive(1'b0, 4'b0000, 4'h0, 0, 0, 0, -1);
    chk("rst_mid_rsp", plog_c.size() == p0,
        $sformatf("%0d responses, expected 0", plog_c.size() - p0));
    chk("rst_mid_req", rlog_m.size() == r0 + 1,
        $sformatf("%0d qs_cs cycles, expected 1", rlog_m.size() - r0));

    // Random traffic with locks, abandons, slave errors, timeouts and resets.
    for (int n = 0; n < 3000; n++)
      cyc_drive(int'($urandom_range(199)) == 0, 4'($urandom), 4'($urandom & $urandom),
                40, 8, 5, -1);
    for (int n = 0; n < 4; n++) cyc_drive(1'b0, 4'h0, 4'h0, 0, 0, 0, -1);
    @(negedge clk);
    chk("req_drain", req_q.size() == 0, $sformatf("%0d requests never seen", req_q.size()));
    chk("rsp_drain", rsp_q.size() == 0, $sformatf("%0d responses never seen", rsp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
